// File: rtl/tx_req_engine.sv
// Transmit request responder: answers scheduler requests from per-queue packet counts,
// emits packet descriptors toward the MAC and rings the scheduler doorbell on enqueue.
module tx_req_engine #(
    parameter int LEN_WIDTH         = 16,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int QUEUE_INDEX_WIDTH = 6,
    parameter int CNT_WIDTH         = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_tx_req_queue,
    input  logic [REQ_TAG_WIDTH-1:0]     s_axis_tx_req_tag,
    input  logic                         s_axis_tx_req_valid,
    output logic                         s_axis_tx_req_ready,
    output logic [LEN_WIDTH-1:0]         m_axis_tx_req_status_len,
    output logic [REQ_TAG_WIDTH-1:0]     m_axis_tx_req_status_tag,
    output logic                         m_axis_tx_req_status_valid,
    input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_enq_queue,
    input  logic [LEN_WIDTH-1:0]         s_axis_enq_len,
    input  logic                         s_axis_enq_valid,
    output logic                         s_axis_enq_ready,
    output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_doorbell_queue,
    output logic                         m_axis_doorbell_valid,
    output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_pkt_queue,
    output logic [LEN_WIDTH-1:0]         m_axis_pkt_len,
    output logic                         m_axis_pkt_valid,
    input  logic                         m_axis_pkt_ready,
    output logic                         stat_enq_drop
);

    localparam int NUM_QUEUES = 1 << QUEUE_INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0]         CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]         CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]         CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [QUEUE_INDEX_WIDTH-1:0] QI_ONE   = {{(QUEUE_INDEX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [QUEUE_INDEX_WIDTH-1:0] QI_LAST  = {QUEUE_INDEX_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_SEND,
        ST_STATUS
    } state_t;

    state_t                         state_q, state_d;
    logic [QUEUE_INDEX_WIDTH-1:0]   init_idx_q, init_idx_d;
    logic [QUEUE_INDEX_WIDTH-1:0]   req_queue_q, req_queue_d;
    logic [REQ_TAG_WIDTH-1:0]       req_tag_q, req_tag_d;
    logic [QUEUE_INDEX_WIDTH-1:0]   pkt_queue_q, pkt_queue_d;
    logic [LEN_WIDTH-1:0]           pkt_len_q, pkt_len_d;
    logic [LEN_WIDTH-1:0]           status_len_q, status_len_d;
    logic                           doorbell_valid_q, doorbell_valid_d;
    logic [QUEUE_INDEX_WIDTH-1:0]   doorbell_queue_q, doorbell_queue_d;
    logic                           drop_q, drop_d;

    logic [CNT_WIDTH-1:0]           cnt_mem [NUM_QUEUES];
    logic [LEN_WIDTH-1:0]           len_mem [NUM_QUEUES];

    logic [CNT_WIDTH-1:0]           lookup_cnt;
    logic [LEN_WIDTH-1:0]           lookup_len;
    logic                           lookup_dec;
    logic                           enq_fire;
    logic                           enq_same;
    logic [CNT_WIDTH-1:0]           enq_cnt_base;
    logic                           enq_room;
    logic [CNT_WIDTH-1:0]           enq_cnt_new;

    assign lookup_cnt = cnt_mem[req_queue_q];
    assign lookup_len = len_mem[req_queue_q];
    assign lookup_dec = (state_q == ST_LOOKUP) && (lookup_cnt != CNT_ZERO);

    // An enqueue colliding with a lookup decrement sees the post-decrement count,
    // so a full queue being drained still accepts the new packet.
    assign enq_fire     = s_axis_enq_valid && s_axis_enq_ready;
    assign enq_same     = lookup_dec && (s_axis_enq_queue == req_queue_q);
    assign enq_cnt_base = cnt_mem[s_axis_enq_queue] - (enq_same ? CNT_ONE : CNT_ZERO);
    assign enq_room     = (enq_cnt_base != CNT_MAX);
    assign enq_cnt_new  = enq_room ? (enq_cnt_base + CNT_ONE) : enq_cnt_base;

    assign doorbell_valid_d = enq_fire && enq_room;
    assign doorbell_queue_d = (enq_fire && enq_room) ? s_axis_enq_queue : doorbell_queue_q;
    assign drop_d           = enq_fire && !enq_room;

    assign s_axis_enq_ready           = (state_q != ST_INIT);
    assign m_axis_tx_req_status_len   = status_len_q;
    assign m_axis_tx_req_status_tag   = req_tag_q;
    assign m_axis_pkt_queue           = pkt_queue_q;
    assign m_axis_pkt_len             = pkt_len_q;
    assign m_axis_doorbell_valid      = doorbell_valid_q;
    assign m_axis_doorbell_queue      = doorbell_queue_q;
    assign stat_enq_drop              = drop_q;

    // Queue memory is deliberately unreset; INIT walks it clear one entry per cycle.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            cnt_mem[init_idx_q] <= CNT_ZERO;
            len_mem[init_idx_q] <= {LEN_WIDTH{1'b0}};
        end else begin
            if (lookup_dec) begin
                cnt_mem[req_queue_q] <= lookup_cnt - CNT_ONE;
            end
            if (enq_fire) begin
                cnt_mem[s_axis_enq_queue] <= enq_cnt_new;
                len_mem[s_axis_enq_queue] <= s_axis_enq_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_INIT;
            init_idx_q       <= '0;
            req_queue_q      <= '0;
            req_tag_q        <= '0;
            pkt_queue_q      <= '0;
            pkt_len_q        <= '0;
            status_len_q     <= '0;
            doorbell_valid_q <= 1'b0;
            doorbell_queue_q <= '0;
            drop_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            init_idx_q       <= init_idx_d;
            req_queue_q      <= req_queue_d;
            req_tag_q        <= req_tag_d;
            pkt_queue_q      <= pkt_queue_d;
            pkt_len_q        <= pkt_len_d;
            status_len_q     <= status_len_d;
            doorbell_valid_q <= doorbell_valid_d;
            doorbell_queue_q <= doorbell_queue_d;
            drop_q           <= drop_d;
        end
    end

    always_comb begin
        state_d                    = state_q;
        init_idx_d                 = init_idx_q;
        req_queue_d                = req_queue_q;
        req_tag_d                  = req_tag_q;
        pkt_queue_d                = pkt_queue_q;
        pkt_len_d                  = pkt_len_q;
        status_len_d               = status_len_q;
        s_axis_tx_req_ready        = 1'b0;
        m_axis_pkt_valid           = 1'b0;
        m_axis_tx_req_status_valid = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + QI_ONE;
                if (init_idx_q == QI_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                s_axis_tx_req_ready = 1'b1;
                if (s_axis_tx_req_valid) begin
                    req_queue_d = s_axis_tx_req_queue;
                    req_tag_d   = s_axis_tx_req_tag;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_cnt != CNT_ZERO) begin
                    pkt_queue_d = req_queue_q;
                    pkt_len_d   = lookup_len;
                    state_d     = ST_SEND;
                end else begin
                    status_len_d = '0;
                    state_d      = ST_STATUS;
                end
            end
            ST_SEND: begin
                m_axis_pkt_valid = 1'b1;
                if (m_axis_pkt_ready) begin
                    status_len_d = pkt_len_q;
                    state_d      = ST_STATUS;
                end
            end
            ST_STATUS: begin
                m_axis_tx_req_status_valid = 1'b1;
                state_d                    = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_req_engine.sv
// Randomized self-checking bench for tx_req_engine against a per-queue count/length model.
module tb_tx_req_engine;

    localparam int LW   = 16;
    localparam int TW   = 8;
    localparam int QW   = 6;
    localparam int CW   = 8;
    localparam int NQ   = 1 << QW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [QW-1:0] s_axis_tx_req_queue;
    logic [TW-1:0] s_axis_tx_req_tag;
    logic          s_axis_tx_req_valid;
    logic          s_axis_tx_req_ready;
    logic [LW-1:0] m_axis_tx_req_status_len;
    logic [TW-1:0] m_axis_tx_req_status_tag;
    logic          m_axis_tx_req_status_valid;
    logic [QW-1:0] s_axis_enq_queue;
    logic [LW-1:0] s_axis_enq_len;
    logic          s_axis_enq_valid;
    logic          s_axis_enq_ready;
    logic [QW-1:0] m_axis_doorbell_queue;
    logic          m_axis_doorbell_valid;
    logic [QW-1:0] m_axis_pkt_queue;
    logic [LW-1:0] m_axis_pkt_len;
    logic          m_axis_pkt_valid;
    logic          m_axis_pkt_ready;
    logic          stat_enq_drop;

    int assertions = 0;
    int failures   = 0;
    int m_cnt [NQ];
    int m_len [NQ];

    tx_req_engine #(
        .LEN_WIDTH(LW), .REQ_TAG_WIDTH(TW), .QUEUE_INDEX_WIDTH(QW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tx_req_queue(s_axis_tx_req_queue),
        .s_axis_tx_req_tag(s_axis_tx_req_tag),
        .s_axis_tx_req_valid(s_axis_tx_req_valid),
        .s_axis_tx_req_ready(s_axis_tx_req_ready),
        .m_axis_tx_req_status_len(m_axis_tx_req_status_len),
        .m_axis_tx_req_status_tag(m_axis_tx_req_status_tag),
        .m_axis_tx_req_status_valid(m_axis_tx_req_status_valid),
        .s_axis_enq_queue(s_axis_enq_queue),
        .s_axis_enq_len(s_axis_enq_len),
        .s_axis_enq_valid(s_axis_enq_valid),
        .s_axis_enq_ready(s_axis_enq_ready),
        .m_axis_doorbell_queue(m_axis_doorbell_queue),
        .m_axis_doorbell_valid(m_axis_doorbell_valid),
        .m_axis_pkt_queue(m_axis_pkt_queue),
        .m_axis_pkt_len(m_axis_pkt_len),
        .m_axis_pkt_valid(m_axis_pkt_valid),
        .m_axis_pkt_ready(m_axis_pkt_ready),
        .stat_enq_drop(stat_enq_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < NQ; i++) begin
            m_cnt[i] = 0;
            m_len[i] = 0;
        end
    endtask

    task automatic model_enq(input int q, input int l, output bit db, output bit drop);
        db   = 1'b0;
        drop = 1'b0;
        if (m_cnt[q] < CMAX) begin
            m_cnt[q]++;
            db = 1'b1;
        end else begin
            drop = 1'b1;
        end
        m_len[q] = l;
    endtask

    task automatic model_req(input int q, output int exp_len, output bit exp_pkt);
        if (m_cnt[q] > 0) begin
            m_cnt[q]--;
            exp_len = m_len[q];
            exp_pkt = 1'b1;
        end else begin
            exp_len = 0;
            exp_pkt = 1'b0;
        end
    endtask

    task automatic wait_req_ready(output bit timeout);
        for (int i = 0; i < 100 && !s_axis_tx_req_ready; i++) tick();
        timeout = !s_axis_tx_req_ready;
    endtask

    // One enqueue beat; the doorbell/drop outputs are sampled one cycle after acceptance.
    task automatic do_enqueue(input int q, input int l, output bit db, output int db_q,
                              output bit drop, output bit rdy_ok);
        s_axis_enq_queue = q[QW-1:0];
        s_axis_enq_len   = l[LW-1:0];
        s_axis_enq_valid = 1'b1;
        rdy_ok           = s_axis_enq_ready;
        tick();
        s_axis_enq_valid = 1'b0;
        db   = m_axis_doorbell_valid;
        db_q = int'(m_axis_doorbell_queue);
        drop = stat_enq_drop;
    endtask

    // Full request transaction; lat counts cycles from the accepting edge to the status pulse.
    task automatic do_request(input int q, input int tag, input int delay,
                              output int st_len, output int st_tag, output bit got_pkt,
                              output int pkt_q, output int pkt_len, output int lat,
                              output bit unstable, output bit timeout);
        int  waited;
        bit  done;
        st_len = -1; st_tag = -1; got_pkt = 0; pkt_q = -1; pkt_len = -1;
        lat = 0; unstable = 0; waited = 0; done = 0;
        m_axis_pkt_ready = 1'b0;
        wait_req_ready(timeout);
        if (timeout) return;
        s_axis_tx_req_queue = q[QW-1:0];
        s_axis_tx_req_tag   = tag[TW-1:0];
        s_axis_tx_req_valid = 1'b1;
        tick();
        s_axis_tx_req_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            if (m_axis_tx_req_status_valid) begin
                st_len = int'(m_axis_tx_req_status_len);
                st_tag = int'(m_axis_tx_req_status_tag);
                done   = 1;
                break;
            end
            if (m_axis_pkt_valid) begin
                if (got_pkt && (pkt_q != int'(m_axis_pkt_queue) || pkt_len != int'(m_axis_pkt_len)))
                    unstable = 1;
                got_pkt = 1;
                pkt_q   = int'(m_axis_pkt_queue);
                pkt_len = int'(m_axis_pkt_len);
                if (waited >= delay) m_axis_pkt_ready = 1'b1;
                else waited++;
            end
            tick();
            lat++;
        end
        m_axis_pkt_ready = 1'b0;
        timeout = !done;
    endtask

    task automatic test_reset;
        bit enq_seen;
        int n;
        rst_n = 1'b0;
        s_axis_tx_req_valid = 0; s_axis_tx_req_queue = 0; s_axis_tx_req_tag = 0;
        s_axis_enq_valid = 0; s_axis_enq_queue = 0; s_axis_enq_len = 0;
        m_axis_pkt_ready = 0;
        repeat (3) tick();
        assertions++;
        if ({s_axis_tx_req_ready, s_axis_enq_ready, m_axis_tx_req_status_valid, m_axis_tx_req_status_len,
             m_axis_tx_req_status_tag, m_axis_doorbell_valid, m_axis_doorbell_queue, m_axis_pkt_valid,
             m_axis_pkt_queue, m_axis_pkt_len, stat_enq_drop} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got nonzero outputs (req_rdy=%b enq_rdy=%b pkt_v=%b st_v=%b) required all zero",
                     s_axis_tx_req_ready, s_axis_enq_ready, m_axis_pkt_valid, m_axis_tx_req_status_valid);
        end
        rst_n = 1'b1;
        n = 0;
        enq_seen = 0;
        while (!s_axis_tx_req_ready && n < 200) begin
            if (s_axis_enq_ready) enq_seen = 1;
            tick();
            n++;
        end
        assertions++;
        if (n != NQ || enq_seen || !s_axis_enq_ready) begin
            failures++;
            $display("[TB] FAIL init_length: got %0d cycles (enq_ready during init=%b) required %0d", n, enq_seen, NQ);
        end
        model_clear();
    endtask

    task automatic test_empty_request;
        int st_len, st_tag, pkt_q, pkt_len, lat;
        bit got_pkt, unstable, to;
        do_request(1, 5, 0, st_len, st_tag, got_pkt, pkt_q, pkt_len, lat, unstable, to);
        assertions++;
        if (to || st_len != 0 || st_tag != 5 || got_pkt || lat != 2 || m_axis_doorbell_valid) begin
            failures++;
            $display("[TB] FAIL empty_request: got len=%0d tag=%0d pkt=%b lat=%0d db=%b to=%b required len=0 tag=5 pkt=0 lat=2 db=0",
                     st_len, st_tag, got_pkt, lat, m_axis_doorbell_valid, to);
        end
        tick();
        assertions++;
        if (m_axis_tx_req_status_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL status_single_cycle: got status_valid=%b required 0", m_axis_tx_req_status_valid);
        end
    endtask

    task automatic test_enq_req;
        bit db, drop, rdy, edb, edrop, got_pkt, unstable, to, exp_pkt;
        int db_q, st_len, st_tag, pkt_q, pkt_len, lat, exp_len;
        for (int i = 0; i < 2; i++) begin
            do_enqueue(2, 64, db, db_q, drop, rdy);
            model_enq(2, 64, edb, edrop);
            assertions++;
            if (!rdy || db != edb || db_q != 2 || drop != edrop) begin
                failures++;
                $display("[TB] FAIL enq_doorbell: got db=%b q=%0d drop=%b rdy=%b required db=%b q=2 drop=%b",
                         db, db_q, drop, rdy, edb, edrop);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_request(2, 1, 0, st_len, st_tag, got_pkt, pkt_q, pkt_len, lat, unstable, to);
            model_req(2, exp_len, exp_pkt);
            assertions++;
            if (to || st_len != exp_len || st_tag != 1 || got_pkt != exp_pkt ||
                (exp_pkt && (pkt_q != 2 || pkt_len != exp_len)) || lat != (exp_pkt ? 3 : 2)) begin
                failures++;
                $display("[TB] FAIL q2_request%0d: got len=%0d tag=%0d pkt=%b pq=%0d plen=%0d lat=%0d required len=%0d tag=1 pkt=%b",
                         i, st_len, st_tag, got_pkt, pkt_q, pkt_len, lat, exp_len, exp_pkt);
            end
        end
    endtask

    task automatic test_backpressure;
        bit db, drop, rdy, edb, edrop, to, exp_pkt;
        int db_q, exp_len;
        do_enqueue(6, 300, db, db_q, drop, rdy);
        model_enq(6, 300, edb, edrop);
        model_req(6, exp_len, exp_pkt);
        wait_req_ready(to);
        m_axis_pkt_ready    = 1'b0;
        s_axis_tx_req_queue = 6'd6;
        s_axis_tx_req_tag   = 8'd9;
        s_axis_tx_req_valid = 1'b1;
        tick();
        s_axis_tx_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 11; i++) begin
            assertions++;
            if (to || {m_axis_pkt_valid, m_axis_pkt_queue, m_axis_pkt_len, m_axis_tx_req_status_valid, s_axis_tx_req_ready}
                      !== {1'b1, 6'd6, exp_len[LW-1:0], 1'b0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d: got pkt_v=%b q=%0d len=%0d st_v=%b req_rdy=%b required pkt_v=1 q=6 len=%0d st_v=0 req_rdy=0",
                         i, m_axis_pkt_valid, m_axis_pkt_queue, m_axis_pkt_len, m_axis_tx_req_status_valid,
                         s_axis_tx_req_ready, exp_len);
            end
            if (i < 10) tick();
        end
        m_axis_pkt_ready = 1'b1;
        tick();
        m_axis_pkt_ready = 1'b0;
        assertions++;
        if ({m_axis_tx_req_status_valid, m_axis_tx_req_status_len, m_axis_tx_req_status_tag, m_axis_pkt_valid}
            !== {1'b1, exp_len[LW-1:0], 8'd9, 1'b0}) begin
            failures++;
            $display("[TB] FAIL hold_release_status: got st_v=%b len=%0d tag=%0d pkt_v=%b required st_v=1 len=%0d tag=9 pkt_v=0",
                     m_axis_tx_req_status_valid, m_axis_tx_req_status_len, m_axis_tx_req_status_tag,
                     m_axis_pkt_valid, exp_len);
        end
    endtask

    task automatic test_saturation;
        bit db, drop, rdy, edb, edrop, got_pkt, unstable, to, exp_pkt;
        int db_q, st_len, st_tag, pkt_q, pkt_len, lat, exp_len, bad;
        bad = 0;
        for (int i = 0; i <= CMAX; i++) begin
            do_enqueue(3, i + 1, db, db_q, drop, rdy);
            model_enq(3, i + 1, edb, edrop);
            assertions++;
            if (!rdy || db != edb || drop != edrop || (edb && db_q != 3)) begin
                failures++;
                $display("[TB] FAIL sat_enq%0d: got db=%b drop=%b q=%0d rdy=%b required db=%b drop=%b",
                         i, db, drop, db_q, rdy, edb, edrop);
            end
        end
        for (int i = 0; i <= CMAX; i++) begin
            do_request(3, i & 8'hff, 0, st_len, st_tag, got_pkt, pkt_q, pkt_len, lat, unstable, to);
            model_req(3, exp_len, exp_pkt);
            assertions++;
            if (to || st_len != exp_len || st_tag != (i & 8'hff) || got_pkt != exp_pkt) begin
                failures++;
                if (bad < 5)
                    $display("[TB] FAIL sat_req%0d: got len=%0d tag=%0d pkt=%b required len=%0d tag=%0d pkt=%b",
                             i, st_len, st_tag, got_pkt, exp_len, i & 8'hff, exp_pkt);
                bad++;
            end
        end
    endtask

    task automatic test_same_cycle;
        bit db, drop, rdy, edb, edrop, got_pkt, unstable, to, exp_pkt;
        int db_q, st_len, st_tag, pkt_q, pkt_len, lat, exp_len;
        do_enqueue(4, 100, db, db_q, drop, rdy);
        model_enq(4, 100, edb, edrop);
        // The lookup observes memory before the colliding enqueue lands.
        model_req(4, exp_len, exp_pkt);
        model_enq(4, 200, edb, edrop);
        wait_req_ready(to);
        s_axis_tx_req_queue = 6'd4;
        s_axis_tx_req_tag   = 8'h44;
        s_axis_tx_req_valid = 1'b1;
        tick();
        s_axis_tx_req_valid = 1'b0;
        s_axis_enq_queue    = 6'd4;
        s_axis_enq_len      = 16'd200;
        s_axis_enq_valid    = 1'b1;
        m_axis_pkt_ready    = 1'b1;
        tick();
        s_axis_enq_valid = 1'b0;
        assertions++;
        if (to || {m_axis_pkt_valid, m_axis_pkt_queue, m_axis_pkt_len, m_axis_doorbell_valid, m_axis_doorbell_queue, stat_enq_drop}
                  !== {exp_pkt, 6'd4, exp_len[LW-1:0], edb, 6'd4, edrop}) begin
            failures++;
            $display("[TB] FAIL collide_desc: got pkt_v=%b q=%0d len=%0d db=%b dbq=%0d drop=%b required pkt_v=1 q=4 len=%0d db=1 dbq=4 drop=0",
                     m_axis_pkt_valid, m_axis_pkt_queue, m_axis_pkt_len, m_axis_doorbell_valid,
                     m_axis_doorbell_queue, stat_enq_drop, exp_len);
        end
        tick();
        m_axis_pkt_ready = 1'b0;
        assertions++;
        if ({m_axis_tx_req_status_valid, m_axis_tx_req_status_len, m_axis_tx_req_status_tag}
            !== {1'b1, exp_len[LW-1:0], 8'h44}) begin
            failures++;
            $display("[TB] FAIL collide_status: got st_v=%b len=%0d tag=%0d required st_v=1 len=%0d tag=68",
                     m_axis_tx_req_status_valid, m_axis_tx_req_status_len, m_axis_tx_req_status_tag, exp_len);
        end
        for (int i = 0; i < 2; i++) begin
            do_request(4, 2 + i, 1, st_len, st_tag, got_pkt, pkt_q, pkt_len, lat, unstable, to);
            model_req(4, exp_len, exp_pkt);
            assertions++;
            if (to || st_len != exp_len || st_tag != 2 + i || got_pkt != exp_pkt || unstable) begin
                failures++;
                $display("[TB] FAIL collide_follow%0d: got len=%0d tag=%0d pkt=%b required len=%0d tag=%0d pkt=%b",
                         i, st_len, st_tag, got_pkt, exp_len, 2 + i, exp_pkt);
            end
        end
        model_req(5, exp_len, exp_pkt);
        model_enq(5, 77, edb, edrop);
        wait_req_ready(to);
        s_axis_tx_req_queue = 6'd5;
        s_axis_tx_req_tag   = 8'h55;
        s_axis_tx_req_valid = 1'b1;
        tick();
        s_axis_tx_req_valid = 1'b0;
        s_axis_enq_queue    = 6'd5;
        s_axis_enq_len      = 16'd77;
        s_axis_enq_valid    = 1'b1;
        tick();
        s_axis_enq_valid = 1'b0;
        assertions++;
        if (to || {m_axis_tx_req_status_valid, m_axis_tx_req_status_len, m_axis_tx_req_status_tag, m_axis_pkt_valid,
                   m_axis_doorbell_valid, m_axis_doorbell_queue} !== {1'b1, exp_len[LW-1:0], 8'h55, 1'b0, edb, 6'd5}) begin
            failures++;
            $display("[TB] FAIL collide_empty: got st_v=%b len=%0d tag=%0d pkt_v=%b db=%b dbq=%0d required st_v=1 len=0 tag=85 pkt_v=0 db=1 dbq=5",
                     m_axis_tx_req_status_valid, m_axis_tx_req_status_len, m_axis_tx_req_status_tag,
                     m_axis_pkt_valid, m_axis_doorbell_valid, m_axis_doorbell_queue);
        end
        do_request(5, 6, 0, st_len, st_tag, got_pkt, pkt_q, pkt_len, lat, unstable, to);
        model_req(5, exp_len, exp_pkt);
        assertions++;
        if (to || st_len != exp_len || got_pkt != exp_pkt || pkt_len != (exp_pkt ? exp_len : -1)) begin
            failures++;
            $display("[TB] FAIL collide_empty_follow: got len=%0d pkt=%b plen=%0d required len=%0d pkt=%b",
                     st_len, got_pkt, pkt_len, exp_len, exp_pkt);
        end
    endtask

    task automatic test_reset_mid;
        bit db, drop, rdy, edb, edrop, got_pkt, unstable, to, exp_pkt, st_seen;
        int db_q, st_len, st_tag, pkt_q, pkt_len, lat, exp_len, n, bad;
        do_enqueue(7, 50, db, db_q, drop, rdy);
        model_enq(7, 50, edb, edrop);
        wait_req_ready(to);
        m_axis_pkt_ready    = 1'b0;
        s_axis_tx_req_queue = 6'd7;
        s_axis_tx_req_tag   = 8'd7;
        s_axis_tx_req_valid = 1'b1;
        tick();
        s_axis_tx_req_valid = 1'b0;
        tick();
        assertions++;
        if (to || m_axis_pkt_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_send: got pkt_v=%b required 1", m_axis_pkt_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        assertions++;
        if ({m_axis_pkt_valid, m_axis_tx_req_status_valid, s_axis_tx_req_ready, s_axis_enq_ready} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midreset_async: got pkt_v=%b st_v=%b req_rdy=%b enq_rdy=%b required all 0",
                     m_axis_pkt_valid, m_axis_tx_req_status_valid, s_axis_tx_req_ready, s_axis_enq_ready);
        end
        st_seen = 0;
        repeat (3) begin
            tick();
            if (m_axis_tx_req_status_valid) st_seen = 1;
        end
        rst_n = 1'b1;
        n = 0;
        while (!s_axis_tx_req_ready && n < 200) begin
            if (m_axis_tx_req_status_valid) st_seen = 1;
            tick();
            n++;
        end
        assertions++;
        if (n != NQ || st_seen) begin
            failures++;
            $display("[TB] FAIL midreset_init: got %0d init cycles status_seen=%b required %0d and 0", n, st_seen, NQ);
        end
        model_clear();
        bad = 0;
        for (int q = 0; q < NQ; q++) begin
            do_request(q, q, 0, st_len, st_tag, got_pkt, pkt_q, pkt_len, lat, unstable, to);
            model_req(q, exp_len, exp_pkt);
            if (to || st_len != exp_len || got_pkt != exp_pkt || st_tag != q) bad++;
        end
        assertions++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL midreset_empty: got %0d non-empty or wrong answers required 0", bad);
        end
    endtask

    task automatic test_random;
        bit db, drop, rdy, edb, edrop, got_pkt, unstable, to, exp_pkt;
        int db_q, st_len, st_tag, pkt_q, pkt_len, lat, exp_len, q, l, tag, dly, shown;
        shown = 0;
        for (int i = 0; i < 250; i++) begin
            q = $urandom_range(7);
            if ($urandom_range(1) == 0) begin
                l = $urandom_range(65535, 1);
                do_enqueue(q, l, db, db_q, drop, rdy);
                model_enq(q, l, edb, edrop);
                assertions++;
                if (!rdy || db != edb || drop != edrop || (edb && db_q != q)) begin
                    failures++;
                    if (shown++ < 5)
                        $display("[TB] FAIL rand_enq%0d: got db=%b q=%0d drop=%b required db=%b q=%0d drop=%b",
                                 i, db, db_q, drop, edb, q, edrop);
                end
            end else begin
                tag = $urandom_range(255);
                dly = $urandom_range(3);
                do_request(q, tag, dly, st_len, st_tag, got_pkt, pkt_q, pkt_len, lat, unstable, to);
                model_req(q, exp_len, exp_pkt);
                assertions++;
                if (to || st_len != exp_len || st_tag != tag || got_pkt != exp_pkt || unstable ||
                    (exp_pkt && (pkt_q != q || pkt_len != exp_len)) || lat != (exp_pkt ? 3 + dly : 2)) begin
                    failures++;
                    if (shown++ < 5)
                        $display("[TB] FAIL rand_req%0d: got len=%0d tag=%0d pkt=%b lat=%0d required len=%0d tag=%0d pkt=%b lat=%0d",
                                 i, st_len, st_tag, got_pkt, lat, exp_len, tag, exp_pkt, exp_pkt ? 3 + dly : 2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_request();
        test_enq_req();
        test_backpressure();
        test_saturation();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
